// File: rtl/vga_cell_scanner_pkg.sv
// rtl/vga_cell_scanner_pkg.sv - shared timing defaults, grid geometry and types
package vga_cell_scanner_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CELL_W   = 10;
    localparam int DEF_CELL_H   = 15;

    localparam int GRID_COLS = 64;
    localparam int GRID_ROWS = 32;
    localparam int COL_W     = $clog2(GRID_COLS);
    localparam int ROW_W     = $clog2(GRID_ROWS);
    localparam int ADDR_W    = ROW_W + COL_W;
    localparam int RGB_W     = 3;
    localparam int CNT_W     = 10;

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/vga_cell_scanner_if.sv
// rtl/vga_cell_scanner_if.sv - video RAM read port and VGA output bundle
interface vga_cell_scanner_if;
    import vga_cell_scanner_pkg::*;

    addr_t addr_read;
    rgb_t  din;
    rgb_t  rgb;
    logic  hsync;
    logic  vsync;
    logic  active;
    logic  frame_start;

    modport master (
        output addr_read, rgb, hsync, vsync, active, frame_start,
        input  din
    );

    modport slave (
        input  addr_read, rgb, hsync, vsync, active, frame_start,
        output din
    );
endinterface

// File: rtl/vga_cell_scanner_timing.sv
// rtl/vga_cell_scanner_timing.sv - pixel divider, h/v counters and raw sync decode
module vga_cell_scanner_timing
    import vga_cell_scanner_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic rst,
    output logic pix_ce,
    output cnt_t h,
    output cnt_t v,
    output logic h_last,
    output logic v_last,
    output logic hsync_raw,
    output logic vsync_raw
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;

    assign pix_ce = (div == DIV_W'(CLK_DIV - 1));
    assign h_last = (h == cnt_t'(H_TOTAL - 1));
    assign v_last = (v == cnt_t'(V_TOTAL - 1));

    // Sync decode of the current counters; the top registers it one pixel later.
    assign hsync_raw = !((h >= cnt_t'(HS_START)) && (h <= cnt_t'(HS_START + H_SYNC - 1)));
    assign vsync_raw = !((v >= cnt_t'(VS_START)) && (v <= cnt_t'(VS_START + V_SYNC - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (pix_ce) begin
            div <= '0;
            h   <= h_last ? '0 : h + 1'b1;
            if (h_last) begin
                v <= v_last ? '0 : v + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end
endmodule

// File: rtl/vga_cell_scanner.sv
// rtl/vga_cell_scanner.sv - scans the cell grid, fetches RAM cells and drives aligned VGA outputs
module vga_cell_scanner
    import vga_cell_scanner_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CELL_W   = DEF_CELL_W,
    parameter int CELL_H   = DEF_CELL_H
) (
    input logic                 clk,
    input logic                 rst,
    vga_cell_scanner_if.master  bus
);
    localparam int SUBX_W = $clog2(CELL_W);
    localparam int SUBY_W = $clog2(CELL_H);

    logic              pix_ce;
    logic              h_last;
    logic              v_last;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              h_vis;
    logic              v_vis;
    cnt_t              h;
    cnt_t              v;
    logic [SUBX_W-1:0] sub_x;
    logic [SUBY_W-1:0] sub_y;
    col_t              col;
    row_t              row;

    vga_cell_scanner_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_ce    (pix_ce),
        .h         (h),
        .v         (v),
        .h_last    (h_last),
        .v_last    (v_last),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    assign h_vis = (h < cnt_t'(H_ACTIVE));
    assign v_vis = (v < cnt_t'(V_ACTIVE));

    // row/col are flops updated with h/v, so the read address is stable all pixel long.
    assign bus.addr_read = {row, col};

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x <= '0;
            sub_y <= '0;
            col   <= '0;
            row   <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                sub_x <= '0;
                col   <= '0;
                if (v_last) begin
                    sub_y <= '0;
                    row   <= '0;
                end else if (v_vis) begin
                    if (sub_y == SUBY_W'(CELL_H - 1)) begin
                        sub_y <= '0;
                        row   <= row + 1'b1;
                    end else begin
                        sub_y <= sub_y + 1'b1;
                    end
                end
            end else if (h_vis) begin
                if (sub_x == SUBX_W'(CELL_W - 1)) begin
                    sub_x <= '0;
                    col   <= col + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end
        end
    end

    // Output stage: h/v still hold the pixel whose cell data is now on din.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rgb         <= '0;
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.active      <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            if (pix_ce) begin
                bus.rgb         <= (h_vis && v_vis) ? bus.din : '0;
                bus.active      <= h_vis && v_vis;
                bus.hsync       <= hsync_raw;
                bus.vsync       <= vsync_raw;
                bus.frame_start <= (h == '0) && (v == '0);
            end
        end
    end
endmodule

// File: tb/tb_vga_cell_scanner.sv
// tb/tb_vga_cell_scanner.sv - directed self-checking bench for vga_cell_scanner
module tb_vga_cell_scanner;
    // Reduced raster so whole frames fit in a short run; cell size stays 10x15.
    localparam int T_HA = 40, T_HFP = 4, T_HS = 6, T_HBP = 6, T_HT = 56;
    localparam int T_VA = 30, T_VFP = 2, T_VS = 2, T_VBP = 3, T_VT = 37;
    localparam int LINE_CLK  = 2 * T_HT;
    localparam int FRAME_CLK = 2 * T_HT * T_VT;
    localparam int BOUND     = 6000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] mem [0:2047];
    int tests = 0;
    int fails = 0;

    vga_cell_scanner_if bus ();

    vga_cell_scanner #(
        .CLK_DIV (2),
        .H_ACTIVE(T_HA), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_ACTIVE(T_VA), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
        .CELL_W  (10),   .CELL_H(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.din <= mem[bus.addr_read];

    task automatic fill_mem(input bit all_white);
        for (int a = 0; a < 2048; a++) mem[a] = all_white ? 3'b111 : 3'(a);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < BOUND);
    endtask

    task automatic test_reset;
        int n, k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.rgb !== 3'd0) begin fails++; $display("FAIL reset_rgb got %0d want 0", bus.rgb); end
        tests++; if (bus.hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync got %0b want 1", bus.hsync); end
        tests++; if (bus.vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync got %0b want 1", bus.vsync); end
        tests++; if (bus.active !== 1'b0) begin fails++; $display("FAIL reset_active got %0b want 0", bus.active); end
        tests++; if (bus.addr_read !== 11'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", bus.addr_read); end
        rst = 1'b0;
        wait_fs(n);
        tests++; if (n != 2) begin fails++; $display("FAIL reset_fs_delay got %0d want 2", n); end
        @(negedge clk);
        tests++; if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs_width got %0b want 0", bus.frame_start); end
        k = 1;
        while (bus.hsync && k < BOUND) begin @(negedge clk); k++; end
        tests++; if (k != 88) begin fails++; $display("FAIL reset_first_hsync got %0d want 88", k); end
    endtask

    task automatic test_line_timing;
        int w, lo, hi, act;
        w = 0;
        while (!bus.hsync && w < BOUND) begin @(negedge clk); w++; end
        while (bus.hsync && w < BOUND) begin @(negedge clk); w++; end
        lo = 0;
        while (!bus.hsync && lo < BOUND) begin @(negedge clk); lo++; end
        hi = 0;
        while (bus.hsync && hi < BOUND) begin @(negedge clk); hi++; end
        tests++; if (lo != 2 * T_HS) begin fails++; $display("FAIL hsync_low got %0d want %0d", lo, 2 * T_HS); end
        tests++; if (lo + hi != LINE_CLK) begin fails++; $display("FAIL hsync_period got %0d want %0d", lo + hi, LINE_CLK); end
        act = 0;
        for (int i = 0; i < LINE_CLK; i++) begin
            act += int'(bus.active);
            @(negedge clk);
        end
        tests++; if (act != 2 * T_HA) begin fails++; $display("FAIL active_per_line got %0d want %0d", act, 2 * T_HA); end
    endtask

    task automatic test_frame_timing;
        int w, lo, hi, fs;
        w = 0;
        while (bus.vsync && w < BOUND) begin @(negedge clk); w++; end
        lo = 0; fs = 0;
        while (!bus.vsync && lo < BOUND) begin fs += int'(bus.frame_start); @(negedge clk); lo++; end
        hi = 0;
        while (bus.vsync && hi < BOUND) begin fs += int'(bus.frame_start); @(negedge clk); hi++; end
        tests++; if (lo != T_VS * LINE_CLK) begin fails++; $display("FAIL vsync_low got %0d want %0d", lo, T_VS * LINE_CLK); end
        tests++; if (lo + hi != FRAME_CLK) begin fails++; $display("FAIL vsync_period got %0d want %0d", lo + hi, FRAME_CLK); end
        tests++; if (fs != 1) begin fails++; $display("FAIL frame_start_count got %0d want 1", fs); end
    endtask

    task automatic test_addressing;
        int px[5], py[5], ea[5], er[5], eact[5];
        int n, cnt, p;
        px = '{10, 25, 39, 45,  5};
        py = '{ 0, 15, 29, 29, 30};
        ea = '{ 1, 66, 67, 68, 128};
        er = '{ 1,  2,  5,  0,  0};
        eact = '{1, 1,  1,  0,  0};
        wait_fs(n);
        tests++; if (n >= BOUND) begin fails++; $display("FAIL addr_sync got %0d want <%0d", n, BOUND); end
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            p = py[i] * T_HT + px[i];
            while (cnt < 2 * p - 1) begin @(negedge clk); cnt++; end
            tests++;
            if (bus.addr_read !== 11'(ea[i])) begin
                fails++; $display("FAIL addr(%0d,%0d) got %0d want %0d", px[i], py[i], bus.addr_read, ea[i]);
            end
            @(negedge clk); cnt++;
            tests++;
            if (bus.rgb !== 3'(er[i])) begin
                fails++; $display("FAIL rgb(%0d,%0d) got %0d want %0d", px[i], py[i], bus.rgb, er[i]);
            end
            tests++;
            if (bus.active !== 1'(eact[i])) begin
                fails++; $display("FAIL active(%0d,%0d) got %0b want %0d", px[i], py[i], bus.active, eact[i]);
            end
            if (i == 1) mem[67] = 3'b101;
        end
        mem[67] = 3'b011;
    endtask

    task automatic test_blanking;
        int n, bad_blank, bad_vis, act;
        fill_mem(1'b1);
        wait_fs(n);
        bad_blank = 0; bad_vis = 0; act = 0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            if (!bus.active && bus.rgb !== 3'd0) bad_blank++;
            if (bus.active && bus.rgb !== 3'b111) bad_vis++;
            act += int'(bus.active);
            @(negedge clk);
        end
        tests++; if (bad_blank != 0) begin fails++; $display("FAIL blank_rgb got %0d nonzero samples want 0", bad_blank); end
        tests++; if (bad_vis != 0) begin fails++; $display("FAIL visible_rgb got %0d wrong samples want 0", bad_vis); end
        tests++; if (act != 2 * T_HA * T_VA) begin fails++; $display("FAIL active_per_frame got %0d want %0d", act, 2 * T_HA * T_VA); end
        fill_mem(1'b0);
    endtask

    task automatic test_reset_midframe;
        int n, cnt, k;
        wait_fs(n);
        cnt = 0;
        while (cnt < 2 * (20 * T_HT + 15)) begin @(negedge clk); cnt++; end
        tests++; if (bus.rgb !== 3'd1) begin fails++; $display("FAIL mid_rgb_before got %0d want 1", bus.rgb); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.rgb !== 3'd0) begin fails++; $display("FAIL mid_rgb got %0d want 0", bus.rgb); end
        tests++; if (bus.active !== 1'b0) begin fails++; $display("FAIL mid_active got %0b want 0", bus.active); end
        tests++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin fails++; $display("FAIL mid_sync got %0b%0b want 11", bus.hsync, bus.vsync); end
        tests++; if (bus.addr_read !== 11'd0) begin fails++; $display("FAIL mid_addr got %0d want 0", bus.addr_read); end
        @(negedge clk);
        rst = 1'b0;
        wait_fs(n);
        tests++; if (n != 2) begin fails++; $display("FAIL mid_fs_delay got %0d want 2", n); end
        k = 0;
        while (bus.hsync && k < BOUND) begin @(negedge clk); k++; end
        tests++; if (k != 88) begin fails++; $display("FAIL mid_first_hsync got %0d want 88", k); end
    endtask

    initial begin
        fill_mem(1'b0);
        test_reset;
        test_line_timing;
        test_frame_timing;
        test_addressing;
        test_blanking;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
